// File: rtl/icache_refill_pkg.sv
// Shared definitions for the instruction-cache line refill engine.
// Holds the FSM state encoding, AXI burst-type constants and parameter defaults.
// Optional build macro: ICACHE_REFILL_WRAP_EN (selects WRAP bursts, critical word first).
package icache_refill_pkg;

  localparam int LINE_WORDS_DEF = 8;
  localparam int INDEX_BITS_DEF = 7;
  localparam int TAG_BITS_DEF   = 20;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/icache_refill.sv
// Purpose: refills one I-cache line over AXI and writes it into the word banks and tag array.
// Latency: miss_req to miss_ack is LINE_WORDS+3 cycles (inclusive) with a ready AXI slave.
// Backpressure: AR waits on ar_ready; R beats are taken only when r_valid is high in DATA.
// Optional macro ICACHE_REFILL_WRAP_EN: WRAP burst from the missing word, else INCR from word 0.
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int TAG_BITS   = TAG_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_req,
  input  logic [31:0]           miss_addr,
  output logic                  miss_ack,
  output logic                  crit_valid,
  output logic [31:0]           crit_data,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  output logic [31:0]           ar_addr,
  output logic [7:0]            ar_len,
  output logic [1:0]            ar_burst,
  input  logic                  r_valid,
  output logic                  r_ready,
  input  logic [31:0]           r_data,
  input  logic                  r_last,
  output logic [LINE_WORDS-1:0] data_wen,
  output logic [31:0]           data_addr,
  output logic [31:0]           data_wdata,
  output logic                  tag_wen,
  output logic [TAG_BITS:0]     tag_wdata,
  output logic                  busy
);

  localparam int WORD_BITS = $clog2(LINE_WORDS);
  localparam int OFF_BITS  = WORD_BITS + 2;
  localparam logic [WORD_BITS-1:0] CNT_ONE = 1;
  localparam logic [LINE_WORDS-1:0] WEN_ONE = 1;

  state_t               r_state;
  state_t               w_next;
  logic [29:0]          r_waddr;   // latched miss_addr[31:2]
  logic [WORD_BITS-1:0] r_cnt;     // bank index of the next beat
  logic [WORD_BITS-1:0] r_beats;   // beats received so far in this burst

  logic                 w_accept;
  logic                 w_beat;
  logic                 w_final;
  logic [WORD_BITS-1:0] w_start;
  logic [WORD_BITS-1:0] w_crit_word;
  logic [31:0]          w_line_addr;
  logic [31:0]          w_ar_addr;
  logic [1:0]           w_ar_burst;
  logic [TAG_BITS-1:0]  w_tag;
  logic                 w_unused;

  assign w_accept    = (r_state == ST_IDLE) && miss_req;
  assign w_beat      = (r_state == ST_DATA) && r_valid;
  // The burst ends on beat count alone, so a misplaced or missing r_last cannot
  // truncate or overrun the line.
  assign w_final     = w_beat && (r_beats == '1);
  assign w_crit_word = r_waddr[WORD_BITS-1:0];
  assign w_line_addr = {r_waddr[29:WORD_BITS], {OFF_BITS{1'b0}}};
  assign w_tag       = r_waddr[OFF_BITS+INDEX_BITS-2 +: TAG_BITS];

  // Byte offset and r_last carry no information this engine acts on.
  assign w_unused    = ^{miss_addr[1:0], r_last};

`ifdef ICACHE_REFILL_WRAP_EN
  assign w_start    = miss_addr[OFF_BITS-1:2];
  assign w_ar_addr  = {r_waddr, 2'b00};
  assign w_ar_burst = AXI_BURST_WRAP;
`else
  assign w_start    = '0;
  assign w_ar_addr  = w_line_addr;
  assign w_ar_burst = AXI_BURST_INCR;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Capture the missing address when a miss is accepted from IDLE.
  always_ff @(posedge clk) begin
    if (rst)           r_waddr <= '0;
    else if (w_accept) r_waddr <= miss_addr[31:2];
  end

  // Bank index and beat count: seeded on acceptance, advanced once per R beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_beats <= '0;
    end else if (w_accept) begin
      r_cnt   <= w_start;
      r_beats <= '0;
    end else if (w_beat) begin
      r_cnt   <= r_cnt + CNT_ONE;
      r_beats <= r_beats + CNT_ONE;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next   = r_state;
    miss_ack = 1'b0;
    ar_valid = 1'b0;
    r_ready  = 1'b0;
    busy     = (r_state != ST_IDLE);
    unique case (r_state)
      ST_IDLE: if (miss_req) w_next = ST_ADDR;
      ST_ADDR: begin
        ar_valid = 1'b1;
        if (ar_ready) w_next = ST_DATA;
      end
      ST_DATA: begin
        r_ready = 1'b1;
        if (w_final) w_next = ST_DONE;
      end
      ST_DONE: begin
        miss_ack = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Address/data outputs are zeroed whenever their strobe is low.
  always_comb begin
    ar_addr    = '0;
    ar_len     = '0;
    ar_burst   = '0;
    data_wen   = '0;
    data_addr  = '0;
    data_wdata = '0;
    crit_valid = 1'b0;
    crit_data  = '0;
    tag_wen    = 1'b0;
    tag_wdata  = '0;
    if (r_state == ST_ADDR) begin
      ar_addr  = w_ar_addr;
      ar_len   = 8'(LINE_WORDS - 1);
      ar_burst = w_ar_burst;
    end
    if (w_beat) begin
      data_wen   = WEN_ONE << r_cnt;
      data_addr  = w_line_addr;
      data_wdata = r_data;
      if (r_cnt == w_crit_word) begin
        crit_valid = 1'b1;
        crit_data  = r_data;
      end
    end
    if (w_final) begin
      tag_wen   = 1'b1;
      tag_wdata = {1'b1, w_tag};
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// Bench for icache_refill: randomized refills checked against a line-level model.
// The expected bank order, critical beat and tag come from address arithmetic only.
module tb_icache_refill;

  localparam int LW = 8;
`ifdef ICACHE_REFILL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          miss_req = 1'b0;
  logic [31:0]   miss_addr = '0;
  logic          miss_ack;
  logic          crit_valid;
  logic [31:0]   crit_data;
  logic          ar_valid;
  logic          ar_ready = 1'b0;
  logic [31:0]   ar_addr;
  logic [7:0]    ar_len;
  logic [1:0]    ar_burst;
  logic          r_valid = 1'b0;
  logic          r_ready;
  logic [31:0]   r_data = '0;
  logic          r_last = 1'b0;
  logic [LW-1:0] data_wen;
  logic [31:0]   data_addr;
  logic [31:0]   data_wdata;
  logic          tag_wen;
  logic [20:0]   tag_wdata;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  icache_refill dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .miss_ack(miss_ack), .crit_valid(crit_valid), .crit_data(crit_data),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_burst(ar_burst), .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .r_last(r_last), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .tag_wen(tag_wen), .tag_wdata(tag_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  // ---------------- observation record (sampled on falling edge) ----------------
  int          q_bank[$];
  logic [31:0] q_wd[$];
  logic [31:0] q_rd[$];
  logic [31:0] q_da[$];
  int          crit_cnt, crit_beat, tag_cnt, tag_beat, ack_cnt;
  int          ar_unstable, bad_onehot, outside, missed;
  logic [31:0] crit_dat, crit_rd, ar_first;
  logic [20:0] tag_dat;
  logic [1:0]  ar_burst_s;
  logic [7:0]  ar_len_s;
  bit          ar_seen;

  task automatic mon_clear();
    q_bank.delete(); q_wd.delete(); q_rd.delete(); q_da.delete();
    crit_cnt = 0; crit_beat = 0; tag_cnt = 0; tag_beat = 0; ack_cnt = 0;
    ar_unstable = 0; bad_onehot = 0; outside = 0; missed = 0;
    crit_dat = '0; crit_rd = '0; ar_first = '0; tag_dat = '0;
    ar_burst_s = '0; ar_len_s = '0; ar_seen = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (data_wen != '0) begin
        if ($countones(data_wen) != 1) bad_onehot++;
        for (int b = 0; b < LW; b++) if (data_wen[b]) q_bank.push_back(b);
        q_wd.push_back(data_wdata);
        q_rd.push_back(r_data);
        q_da.push_back(data_addr);
      end else if (r_valid && r_ready) begin
        missed++;
      end
      if (crit_valid) begin crit_cnt++; crit_beat = q_bank.size(); crit_dat = crit_data; crit_rd = r_data; end
      if (tag_wen) begin tag_cnt++; tag_beat = q_bank.size(); tag_dat = tag_wdata; end
      if (miss_ack) ack_cnt++;
      if (ar_valid) begin
        if (!ar_seen) begin ar_seen = 1; ar_first = ar_addr; end
        else if (ar_addr !== ar_first) ar_unstable++;
        ar_burst_s = ar_burst;
        ar_len_s   = ar_len;
      end
      if (!r_ready && (data_wen != '0 || tag_wen || crit_valid)) outside++;
    end
  end

  // ---------------- reference model ----------------
  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % LW);
  endfunction
  function automatic int exp_bank(input logic [31:0] a, input int k);
    int s = WRAP ? word_of(a) : 0;
    return (s + k) % LW;
  endfunction
  function automatic int exp_crit_beat(input logic [31:0] a);
    int s = WRAP ? word_of(a) : 0;
    return ((word_of(a) - s + LW) % LW) + 1;
  endfunction
  function automatic logic [31:0] exp_ar_addr(input logic [31:0] a);
    return WRAP ? (a & ~32'h3) : (a & ~32'h1F);
  endfunction
  function automatic logic [20:0] exp_tag(input logic [31:0] a);
    return {1'b1, a[31:12]};
  endfunction

  // ---------------- stimulus driver ----------------
  // Drives one miss; returns latency (cycle of miss_ack, miss_req cycle = 1) or -1.
  // stop_beats > 0 returns early once that many beats were accepted.
  task automatic run_refill(input logic [31:0] addr, input int ar_delay, input bit toggle,
                            input int last_beat, input int stop_beats, output int lat);
    int beats = 0;
    int arwait = 0;
    int cyc = 1;
    bit done = 0;
    lat = -1;
    mon_clear();
    @(posedge clk); #1;
    miss_req = 1; miss_addr = addr;
    ar_ready = (ar_delay == 0);
    r_valid = 1; r_data = $urandom; r_last = (last_beat == 1);
    while (!done) begin
      @(negedge clk);
      if (miss_ack) lat = cyc;
      if (ar_valid) arwait++;
      if (r_valid && r_ready) beats++;
      @(posedge clk); #1;
      cyc++;
      if (lat >= 0) done = 1;
      else if (stop_beats > 0 && beats >= stop_beats) done = 1;
      else if (cyc > 300) done = 1;
      ar_ready = (arwait >= ar_delay);
      r_valid  = toggle ? ~r_valid : 1'b1;
      r_data   = $urandom;
      r_last   = (beats + 1 == last_beat);
    end
    miss_req = 0; ar_ready = 0; r_valid = 0; r_last = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; r_valid = 1; r_data = 32'hDEAD_BEEF; miss_req = 1; miss_addr = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if ({miss_ack, crit_valid, ar_valid, r_ready, tag_wen} !== 5'b0) begin
      miscompares++; $display("FAIL reset_strobes: got %b expected 00000", {miss_ack, crit_valid, ar_valid, r_ready, tag_wen}); end
    vectors++; if (data_wen !== '0) begin miscompares++; $display("FAIL reset_wen: got %h expected 0", data_wen); end
    vectors++; if ({ar_addr, ar_len, ar_burst, data_addr, data_wdata, crit_data, tag_wdata} !== '0) begin
      miscompares++; $display("FAIL reset_buses: got %h expected 0", {ar_addr, ar_len, ar_burst, data_addr, data_wdata, crit_data, tag_wdata}); end
    @(posedge clk); #1;
    rst = 0; r_valid = 0; miss_req = 0;
  endtask

  task automatic test_spec_vector();
    logic [31:0] a = 32'h1FC0_0014;
    int lat;
    run_refill(a, 0, 0, LW, 0, lat);
    @(negedge clk);
    vectors++; if (lat !== LW + 3) begin miscompares++; $display("FAIL latency: got %0d expected %0d", lat, LW + 3); end
    vectors++; if (ar_first !== (WRAP ? 32'h1FC0_0014 : 32'h1FC0_0000)) begin
      miscompares++; $display("FAIL ar_addr: got %h expected %h", ar_first, WRAP ? 32'h1FC0_0014 : 32'h1FC0_0000); end
    vectors++; if (ar_burst_s !== (WRAP ? 2'd2 : 2'd1)) begin
      miscompares++; $display("FAIL ar_burst: got %0d expected %0d", ar_burst_s, WRAP ? 2 : 1); end
    vectors++; if (ar_len_s !== 8'(LW - 1)) begin miscompares++; $display("FAIL ar_len: got %0d expected %0d", ar_len_s, LW - 1); end
    vectors++; if (q_bank.size() !== LW) begin miscompares++; $display("FAIL spec_beats: got %0d expected %0d", q_bank.size(), LW); end
    for (int k = 0; k < LW && k < q_bank.size(); k++) begin
      vectors++; if (q_bank[k] !== exp_bank(a, k)) begin
        miscompares++; $display("FAIL spec_bank[%0d]: got %0d expected %0d", k, q_bank[k], exp_bank(a, k)); end
      vectors++; if (q_wd[k] !== q_rd[k] || q_da[k] !== 32'h1FC0_0000) begin
        miscompares++; $display("FAIL spec_wdata[%0d]: got %h@%h expected %h@1fc00000", k, q_wd[k], q_da[k], q_rd[k]); end
    end
    vectors++; if (crit_cnt !== 1 || crit_beat !== (WRAP ? 1 : 6)) begin
      miscompares++; $display("FAIL spec_crit: got %0d pulses at beat %0d expected 1 at beat %0d", crit_cnt, crit_beat, WRAP ? 1 : 6); end
    vectors++; if (crit_dat !== crit_rd) begin miscompares++; $display("FAIL spec_crit_data: got %h expected %h", crit_dat, crit_rd); end
    vectors++; if (tag_cnt !== 1 || tag_dat !== 21'h1_1FC00) begin
      miscompares++; $display("FAIL spec_tag: got %0d writes of %h expected 1 of 11fc00", tag_cnt, tag_dat); end
    vectors++; if (ack_cnt !== 1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL spec_ack: got acks=%0d busy=%b expected acks=1 busy=0", ack_cnt, busy); end
  endtask

  task automatic test_slow_axi();
    logic [31:0] a = $urandom;
    int lat;
    run_refill(a, 4, 1, LW, 0, lat);
    @(negedge clk);
    vectors++; if (lat < 0) begin miscompares++; $display("FAIL slow_done: got no miss_ack expected one"); end
    vectors++; if (ar_unstable !== 0 || ar_first !== exp_ar_addr(a)) begin
      miscompares++; $display("FAIL slow_ar: got %h changes=%0d expected %h stable", ar_first, ar_unstable, exp_ar_addr(a)); end
    vectors++; if (q_bank.size() !== LW) begin miscompares++; $display("FAIL slow_writes: got %0d expected %0d", q_bank.size(), LW); end
    for (int k = 0; k < LW && k < q_bank.size(); k++) begin
      vectors++; if (q_bank[k] !== exp_bank(a, k)) begin
        miscompares++; $display("FAIL slow_bank[%0d]: got %0d expected %0d", k, q_bank[k], exp_bank(a, k)); end
    end
    vectors++; if (ack_cnt !== 1 || tag_cnt !== 1) begin
      miscompares++; $display("FAIL slow_ack: got acks=%0d tags=%0d expected 1/1", ack_cnt, tag_cnt); end
    vectors++; if (missed !== 0 || bad_onehot !== 0 || outside !== 0) begin
      miscompares++; $display("FAIL slow_strobes: got missed=%0d multi=%0d outside=%0d expected 0", missed, bad_onehot, outside); end
  endtask

  task automatic test_early_last();
    logic [31:0] a = $urandom;
    int lat;
    run_refill(a, 0, 0, 6, 0, lat);
    vectors++; if (lat !== LW + 3) begin miscompares++; $display("FAIL early_lat: got %0d expected %0d", lat, LW + 3); end
    vectors++; if (q_bank.size() !== LW) begin miscompares++; $display("FAIL early_writes: got %0d expected %0d", q_bank.size(), LW); end
    vectors++; if (tag_cnt !== 1 || tag_beat !== LW || tag_dat !== exp_tag(a)) begin
      miscompares++; $display("FAIL early_tag: got %0d at beat %0d data %h expected 1 at beat %0d data %h",
                              tag_cnt, tag_beat, tag_dat, LW, exp_tag(a)); end
  endtask

  task automatic test_abort();
    logic [31:0] a = $urandom;
    logic [31:0] b = $urandom;
    int lat;
    run_refill(a, 0, 0, LW, 3, lat);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || data_wen !== '0) begin
      miscompares++; $display("FAIL abort_idle: got busy=%b wen=%h expected 0/0", busy, data_wen); end
    vectors++; if (tag_cnt !== 0 || ack_cnt !== 0) begin
      miscompares++; $display("FAIL abort_tag: got tags=%0d acks=%0d expected 0/0", tag_cnt, ack_cnt); end
    vectors++; if (q_bank.size() !== 3) begin miscompares++; $display("FAIL abort_writes: got %0d expected 3", q_bank.size()); end
    run_refill(b, 0, 0, LW, 0, lat);
    vectors++; if (lat !== LW + 3 || tag_cnt !== 1 || tag_dat !== exp_tag(b)) begin
      miscompares++; $display("FAIL abort_rerun: got lat=%0d tags=%0d tag=%h expected %0d/1/%h", lat, tag_cnt, tag_dat, LW + 3, exp_tag(b)); end
    for (int k = 0; k < LW && k < q_bank.size(); k++) begin
      vectors++; if (q_bank[k] !== exp_bank(b, k)) begin
        miscompares++; $display("FAIL abort_bank[%0d]: got %0d expected %0d", k, q_bank[k], exp_bank(b, k)); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      logic [31:0] a = $urandom;
      int dly = $urandom_range(0, 3);
      bit tog = 1'($urandom_range(0, 1));
      int lb  = $urandom_range(0, LW);
      int lat;
      run_refill(a, dly, tog, lb, 0, lat);
      @(negedge clk);
      vectors++; if (q_bank.size() !== LW) begin miscompares++; $display("FAIL rnd%0d_writes: got %0d expected %0d", it, q_bank.size(), LW); end
      for (int k = 0; k < LW && k < q_bank.size(); k++) begin
        vectors++; if (q_bank[k] !== exp_bank(a, k) || q_wd[k] !== q_rd[k] || q_da[k] !== (a & ~32'h1F)) begin
          miscompares++; $display("FAIL rnd%0d_beat%0d: got bank %0d %h@%h expected bank %0d %h@%h",
                                  it, k, q_bank[k], q_wd[k], q_da[k], exp_bank(a, k), q_rd[k], a & ~32'h1F); end
      end
      vectors++; if (crit_cnt !== 1 || crit_beat !== exp_crit_beat(a) || crit_dat !== crit_rd) begin
        miscompares++; $display("FAIL rnd%0d_crit: got %0d at beat %0d expected 1 at beat %0d", it, crit_cnt, crit_beat, exp_crit_beat(a)); end
      vectors++; if (tag_cnt !== 1 || tag_beat !== LW || tag_dat !== exp_tag(a)) begin
        miscompares++; $display("FAIL rnd%0d_tag: got %0d at beat %0d data %h expected 1 at beat %0d data %h",
                                it, tag_cnt, tag_beat, tag_dat, LW, exp_tag(a)); end
      vectors++; if (ack_cnt !== 1 || busy !== 1'b0 || ar_first !== exp_ar_addr(a) || bad_onehot !== 0) begin
        miscompares++; $display("FAIL rnd%0d_ctl: got acks=%0d busy=%b ar=%h multi=%0d expected 1/0/%h/0",
                                it, ack_cnt, busy, ar_first, bad_onehot, exp_ar_addr(a)); end
    end
  endtask

  initial begin
    mon_clear();
    test_reset();
    test_spec_vector();
    test_slow_axi();
    test_early_last();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
